pill_event_scheduler: RTL and testbench
=======================================

PILL_EVENT_SCHEDULER -- requirements
Module: pill_event_scheduler

Interface
REQ-001 The block SHALL have parameter TOTAL_PILLS, default 10'd244, pills in one level including power pellets.
REQ-002 The block SHALL have parameter POWER_CYCLES, default 16'd6000, clocks of power mode per pellet.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  level-start request, sampled on clk.
REQ-006 The block SHALL have port collision_type  input  4  collision code from the collision detector.
REQ-007 The block SHALL have port pill_count  output  10  pills eaten this level, binary, feeds the BCD/hex display path.
REQ-008 The block SHALL have port power_active  output  1  high while in POWER state.
REQ-009 The block SHALL have port power_warn  output  1  high in POWER when remaining timer < POWER_CYCLES/4.
REQ-010 The block SHALL have port level_clear  output  1  high while in CLEAR state.
REQ-011 The block SHALL have port event_ack  output  1  one-cycle pulse per accepted pill/pellet event.

Function
REQ-012 Codes: 4'b0010 = pill, 4'b0100 = power pellet; all other codes SHALL be ignored.
REQ-013 A registered copy prev_type of collision_type SHALL be kept every cycle, in all states.
REQ-014 An event SHALL be valid only when collision_type is pill or pellet and differs from prev_type; a code held N cycles yields exactly one event.
REQ-015 States: IDLE, PLAY, POWER, CLEAR; events SHALL be accepted only in PLAY and POWER.
REQ-016 IDLE: start=1 -> PLAY, pill_count cleared to 0.
REQ-017 Accepted event SHALL increment pill_count at the sampling edge and pulse event_ack in the following cycle (both registered, 1-cycle latency).
REQ-018 PLAY: accepted pellet -> POWER, timer loaded with POWER_CYCLES-1.
REQ-019 POWER: timer decrements by 1 per cycle; at timer==0 with no pellet -> PLAY.
REQ-020 POWER: accepted pellet SHALL reload timer to POWER_CYCLES-1 (no accumulation).
REQ-021 Any state: accepted event making pill_count == TOTAL_PILLS -> CLEAR; CLEAR has priority over POWER entry/reload; power_active drops the same edge.
REQ-022 CLEAR: pill_count SHALL hold at TOTAL_PILLS; start=1 -> PLAY with pill_count=0.
REQ-023 start SHALL be ignored in PLAY and POWER.
REQ-024 pill_count SHALL never exceed TOTAL_PILLS; no wrap-around.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, pill_count=0, timer=0, prev_type=4'b0000, all 1-bit outputs 0.
REQ-026 Reset asserted mid-POWER or mid-event SHALL discard the event; no event_ack after reset release.
REQ-027 First cycle after reset release with collision_type=pill held SHALL count as an event only once PLAY is reached and the code differs from prev_type.

Structure
REQ-028 Collision code constants, state enum and power-timer width SHALL live in shared package pacman_pkg.
REQ-029 The power timer (load, decrement, zero, warn flag) SHALL be sub-module power_timer; the FSM and counter stay in pill_event_scheduler.

Verification (POWER_CYCLES=8, TOTAL_PILLS=5 in bench)
REQ-030 Reset, start, pill code held 4 cycles -> pill_count=1, exactly one event_ack pulse.
REQ-031 Alternate 0010/0000 three times -> pill_count=3, three event_ack pulses one cycle after each sample.
REQ-032 Pellet in PLAY -> power_active=1 for 8 cycles, power_warn=1 for final 2; second pellet at cycle 5 -> 8 more cycles from reload.
REQ-033 Fifth event is a pellet -> level_clear=1, power_active=0, pill_count=5; further pills ignored; start -> PLAY, pill_count=0.
REQ-034 reset_n low mid-POWER -> all outputs 0 immediately, without waiting for clk; after release, start required before counting.
REQ-035 Codes 0110/1111 and events in IDLE -> pill_count unchanged, no event_ack.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared constants for the pill/pellet scoring path: collision codes, scheduler
// state encoding and power-timer width.
package pacman_pkg;

  localparam logic [3:0] CodePill   = 4'b0010;
  localparam logic [3:0] CodePellet = 4'b0100;

  localparam int unsigned PowerTimerWidth = 16;

  // Kept as plain localparams so older tools see a fixed 2-bit encoding.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StPlay  = 2'd1;
  localparam state_t StPower = 2'd2;
  localparam state_t StClear = 2'd3;

  // Only pills and power pellets score; every other collision code is ignored.
  function automatic logic is_scoring_code(input logic [3:0] code);
    return (code == CodePill) || (code == CodePellet);
  endfunction

endpackage

// File: rtl/pill_event_scheduler_if.sv
// Collision input and scoring/status outputs of the pill event scheduler.
interface pill_event_scheduler_if;

  logic       start;
  logic [3:0] collision_type;
  logic [9:0] pill_count;
  logic       power_active;
  logic       power_warn;
  logic       level_clear;
  logic       event_ack;

  // Game logic side: requests levels, reports collisions, reads status.
  modport master (
    output start,
    output collision_type,
    input  pill_count,
    input  power_active,
    input  power_warn,
    input  level_clear,
    input  event_ack
  );

  // Scheduler side.
  modport slave (
    input  start,
    input  collision_type,
    output pill_count,
    output power_active,
    output power_warn,
    output level_clear,
    output event_ack
  );

endinterface

// File: rtl/power_timer.sv
// Power-mode countdown: loads POWER_CYCLES-1, counts down to zero while running,
// and flags the last quarter of the power period.
module power_timer
  import pacman_pkg::*;
#(
  parameter logic [PowerTimerWidth-1:0] POWER_CYCLES = 16'd6000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic zero,
  output logic warn
);

  localparam logic [PowerTimerWidth-1:0] LoadValue = POWER_CYCLES - PowerTimerWidth'(1);
  localparam logic [PowerTimerWidth-1:0] WarnLimit = POWER_CYCLES >> 2;

  logic [PowerTimerWidth-1:0] count_q;

  // Load wins over countdown; outside power mode the timer rests at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LoadValue;
    end else if (!run) begin
      count_q <= '0;
    end else if (count_q != '0) begin
      count_q <= count_q - PowerTimerWidth'(1);
    end
  end

  assign zero = (count_q == '0);
  assign warn = (count_q < WarnLimit);

endmodule

// File: rtl/pill_event_scheduler.sv
// Level scoring FSM: edge-detects pill/pellet collisions, counts pills eaten,
// runs power mode via power_timer and signals level clear.
module pill_event_scheduler
  import pacman_pkg::*;
#(
  parameter logic [9:0]                 TOTAL_PILLS  = 10'd244,
  parameter logic [PowerTimerWidth-1:0] POWER_CYCLES = 16'd6000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pill_event_scheduler_if.slave  bus
);

  state_t     state_q, state_d;
  logic [9:0] count_q, count_d;
  logic [3:0] prev_type_q;
  logic       ack_q;

  logic [3:0] code;
  logic [9:0] count_inc;
  logic       in_game;
  logic       accept;
  logic       hits_total;
  logic       timer_load;
  logic       timer_zero;
  logic       timer_warn;

  // Event qualification: a scoring code counts once, on the cycle it first appears.
  always_comb begin
    code       = bus.collision_type;
    count_inc  = count_q + 10'd1;
    in_game    = (state_q == StPlay) || (state_q == StPower);
    accept     = is_scoring_code(code) && (code != prev_type_q) && in_game &&
                 (count_q < TOTAL_PILLS);
    hits_total = accept && (count_inc == TOTAL_PILLS);
    // Clearing the level takes priority over entering or extending power mode.
    timer_load = accept && (code == CodePellet) && !hits_total;
  end

  // Next-state and pill counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle, StClear: begin
        if (bus.start) begin
          state_d = StPlay;
          count_d = '0;
        end
      end
      StPlay: begin
        if (timer_load) state_d = StPower;
      end
      StPower: begin
        if (!timer_load && timer_zero) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase
    if (accept)     count_d = count_inc;
    if (hits_total) state_d = StClear;
  end

  // State, counter, collision history and ack pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      prev_type_q <= 4'b0000;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prev_type_q <= code;
      ack_q       <= accept;
    end
  end

  power_timer #(
    .POWER_CYCLES(POWER_CYCLES)
  ) u_power_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .run    (state_q == StPower),
    .zero   (timer_zero),
    .warn   (timer_warn)
  );

  assign bus.pill_count   = count_q;
  assign bus.power_active = (state_q == StPower);
  assign bus.power_warn   = (state_q == StPower) && timer_warn;
  assign bus.level_clear  = (state_q == StClear);
  assign bus.event_ack    = ack_q;

endmodule

// File: tb/tb_pill_event_scheduler.sv
// Bench for pill_event_scheduler with TOTAL_PILLS=5, POWER_CYCLES=8: directed
// scenarios with literal expectations, then random collisions against a model.
module tb_pill_event_scheduler;

  localparam int Total = 5;
  localparam int Pc    = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  pill_event_scheduler_if bus ();

  pill_event_scheduler #(
    .TOTAL_PILLS (10'd5),
    .POWER_CYCLES(16'd8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit chk_en    = 1'b0;

  // Model: level in progress, level cleared, power cycles still to run.
  int m_count, m_left, m_prev;
  bit m_playing, m_cleared, m_ack;

  int n_ack, n_pa, n_warn;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_left = 0; m_prev = 0;
    m_playing = 0; m_cleared = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit s, input int c);
    bit ev;
    ev     = ((c == 2) || (c == 4)) && (c != m_prev);
    m_prev = c;
    m_ack  = 0;
    if (!m_playing) begin
      if (s) begin
        m_playing = 1; m_cleared = 0; m_count = 0; m_left = 0;
      end
    end else if (ev) begin
      m_ack = 1;
      m_count++;
      if (m_count == Total) begin
        m_playing = 0; m_cleared = 1; m_left = 0;
      end else if (c == 4) begin
        m_left = Pc;
      end else if (m_left > 0) begin
        m_left--;
      end
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pill_count", int'(bus.pill_count), m_count);
      check("power_active", int'(bus.power_active), int'(m_left > 0));
      check("power_warn", int'(bus.power_warn), int'(m_left > 0 && m_left <= Pc / 4));
      check("level_clear", int'(bus.level_clear), int'(m_cleared));
      check("event_ack", int'(bus.event_ack), int'(m_ack));
    end
  end

  task automatic clr_counts();
    n_ack = 0; n_pa = 0; n_warn = 0;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit s, input int c);
    bus.start          = s;
    bus.collision_type = 4'(c);
    @(posedge clk);
    model_step(s, c);
    @(negedge clk);
    if (bus.event_ack)    n_ack++;
    if (bus.power_active) n_pa++;
    if (bus.power_warn)   n_warn++;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_pill_count", int'(bus.pill_count), 0);
    check("rst_power_active", int'(bus.power_active), 0);
    check("rst_power_warn", int'(bus.power_warn), 0);
    check("rst_level_clear", int'(bus.level_clear), 0);
    check("rst_event_ack", int'(bus.event_ack), 0);
    @(negedge clk);
    reset_n   = 1'b1;
    bus.start = 1'b0;
  endtask

  int codes [8] = '{0, 2, 4, 2, 0, 6, 15, 1};

  initial begin
    bus.start          = 1'b0;
    bus.collision_type = 4'd0;
    model_reset();
    clr_counts();
    #3;
    check("init_pill_count", int'(bus.pill_count), 0);
    check("init_power_active", int'(bus.power_active), 0);
    check("init_level_clear", int'(bus.level_clear), 0);
    check("init_event_ack", int'(bus.event_ack), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Scoring codes in IDLE are ignored.
    step(0, 2); step(0, 0); step(0, 4); step(0, 6);
    check("idle_count", int'(bus.pill_count), 0);
    check("idle_acks", n_ack, 0);

    // Pill held four cycles is one event.
    step(1, 0);
    clr_counts();
    repeat (4) step(0, 2);
    step(0, 0);
    check("held_count", int'(bus.pill_count), 1);
    check("held_acks", n_ack, 1);

    // Non-scoring codes in PLAY; start ignored in PLAY.
    clr_counts();
    step(0, 6); step(1, 15); step(0, 0); step(0, 6); step(0, 15);
    check("junk_count", int'(bus.pill_count), 1);
    check("junk_acks", n_ack, 0);

    // Alternating pill/none three times.
    mid_reset();
    step(1, 0);
    clr_counts();
    repeat (3) begin
      step(0, 2);
      check("alt_ack_pulse", int'(bus.event_ack), 1);
      step(0, 0);
    end
    check("alt_count", int'(bus.pill_count), 3);
    check("alt_acks", n_ack, 3);

    // Single pellet: 8 power cycles, last 2 warned.
    mid_reset();
    step(1, 0);
    clr_counts();
    step(0, 4);
    repeat (12) step(0, 0);
    check("pwr_cycles", n_pa, 8);
    check("pwr_warn_cycles", n_warn, 2);

    // Reload at the fifth power cycle gives 8 more from the reload.
    step(0, 4);
    repeat (3) step(0, 0);
    clr_counts();
    step(0, 4);
    repeat (12) step(0, 0);
    check("reload_cycles", n_pa, 8);
    check("reload_warn_cycles", n_warn, 2);
    check("reload_count", int'(bus.pill_count), 3);

    // Fifth event is a pellet: clear wins over power.
    step(0, 2); step(0, 0); step(0, 4);
    check("clr_level_clear", int'(bus.level_clear), 1);
    check("clr_power_active", int'(bus.power_active), 0);
    check("clr_count", int'(bus.pill_count), 5);
    clr_counts();
    step(0, 2); step(0, 0); step(0, 2); step(0, 4);
    check("clr_hold_count", int'(bus.pill_count), 5);
    check("clr_hold_acks", n_ack, 0);
    step(1, 0);
    check("restart_count", int'(bus.pill_count), 0);
    check("restart_clear", int'(bus.level_clear), 0);

    // Reset mid-POWER; then a held pill after release needs start and a new edge.
    step(0, 2); step(0, 4); step(0, 0);
    mid_reset();
    clr_counts();
    step(0, 2); step(0, 2); step(0, 2);
    step(1, 2); step(0, 2);
    check("post_rst_count", int'(bus.pill_count), 0);
    check("post_rst_acks", n_ack, 0);
    step(0, 0); step(0, 2);
    check("post_rst_first", int'(bus.pill_count), 1);

    // Random collisions against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 9) == 0, codes[$urandom_range(0, 7)]);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
